// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer driving mux select and serializer strobes.
// Optional UART_TX_TWO_STOP_EN adds a second stop bit (STOP2 state).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_load,
  output logic       ser_shift,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
  localparam state_t LAST_STOP = STOP2;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t LAST_STOP = STOP;
`endif
  state_t state;
  logic [CW-1:0] bit_cnt;
  logic par_en_q;
  logic last_bit, last_stop, illegal;
  assign last_bit   = bit_cnt == CW'(DATA_WIDTH - 1);
  assign last_stop  = state == LAST_STOP;
  assign illegal    = state > LAST_STOP;
  assign busy       = state != IDLE;
  assign ser_load   = rst & tick & data_valid & (state == IDLE | last_stop);
  assign ser_shift  = rst & tick & state == DATA & !last_bit;
  assign frame_done = rst & tick & last_stop;
  // mux_sel is loaded alongside the next state so it always matches the current bit phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      mux_sel  <= 2'b01;
    end else if (illegal) begin
      state   <= IDLE;
      bit_cnt <= '0;
      mux_sel <= 2'b01;
    end else if (tick) begin
      case (state)
        IDLE: if (data_valid) begin
          state    <= START;
          mux_sel  <= 2'b00;
          par_en_q <= par_en;
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          mux_sel <= 2'b10;
        end
        DATA: if (!last_bit) bit_cnt <= bit_cnt + CW'(1);
          else begin
            state   <= par_en_q ? PARITY : STOP;
            mux_sel <= par_en_q ? 2'b11 : 2'b01;
          end
        PARITY: begin
          state   <= STOP;
          mux_sel <= 2'b01;
        end
`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          state   <= STOP2;
          mux_sel <= 2'b01;
        end
        STOP2: begin
          state    <= data_valid ? START : IDLE;
          mux_sel  <= data_valid ? 2'b00 : 2'b01;
          par_en_q <= data_valid ? par_en : par_en_q;
        end
`else
        STOP: begin
          state    <= data_valid ? START : IDLE;
          mux_sel  <= data_valid ? 2'b00 : 2'b01;
          par_en_q <= data_valid ? par_en : par_en_q;
        end
`endif
        default: begin
          state   <= IDLE;
          mux_sel <= 2'b01;
        end
      endcase
    end
  end
endmodule
